uart_mmio: RTL and testbench

Parametrised memory-mapped UART for the processor data bus. It replaces the fixed-baud, fixed-buffer UART with the following:
- runtime-programmable baud divisor
- optional parity and 1/2 stop bits
- independent RX and TX FIFOs of configurable depth
- sticky error flags
- a level interrupt

It sits on the data-memory address decoder beside RAM and is accessed by word loads and stores.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_fifo.sv | 51 +++++
 rtl/uart_mmio.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM encodings for uart_mmio.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_FULL      = 3;
  localparam int ST_TX_BUSY      = 4;
  localparam int ST_OVERRUN      = 5;
  localparam int ST_PARITY_ERR   = 6;
  localparam int ST_FRAME_ERR    = 7;
  localparam int ST_RX_COUNT_LSB = 8;

  localparam int CT_PAR_EN    = 16;
  localparam int CT_PAR_ODD   = 17;
  localparam int CT_STOP2     = 18;
  localparam int CT_RX_IRQ_EN = 19;
  localparam int CT_TX_IRQ_EN = 20;
  localparam int CT_LOOPBACK  = 21;

  // 50 MHz / 9600 baud / 16 oversample, minus one.
  localparam int DIV_RESET_DEFAULT = 325;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Power-of-two synchronous FIFO; a pop frees a slot for a same-cycle push when full.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: programmable baud, parity/stop options, RX/TX FIFOs, sticky errors, level irq.
// Define UART_LOOPBACK_EN to make CTRL[21] route TX back into RX internally.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int RX_DEPTH   = 8,
  parameter int TX_DEPTH   = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = DIV_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [31:0] w_data,
  input  logic        we,
  input  logic        re,
  output logic [31:0] r_data,
  input  logic        i_Rx,
  output logic        o_Tx,
  output logic        irq
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [1:0] reg_sel;
  logic       wr_data, wr_ctrl, wr_clear, rx_pop;
  assign reg_sel  = address[3:2];
  assign wr_data  = we && reg_sel == REG_DATA;
  assign wr_ctrl  = we && reg_sel == REG_CTRL;
  assign wr_clear = we && reg_sel == REG_CLEAR;
  assign rx_pop   = re && reg_sel == REG_DATA;

  logic unused_bits;
  assign unused_bits = ^{address[15:4], address[1:0], w_data};

  logic [DIV_W-1:0] divisor;
  logic par_en, par_odd, stop2, rx_irq_en, tx_irq_en, loopback;

  always_ff @(posedge clk) begin
    if (reset) begin
      divisor   <= DIV_W'(DIV_RESET);
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      stop2     <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      divisor   <= w_data[DIV_W-1:0];
      par_en    <= w_data[CT_PAR_EN];
      par_odd   <= w_data[CT_PAR_ODD];
      stop2     <= w_data[CT_STOP2];
      rx_irq_en <= w_data[CT_RX_IRQ_EN];
      tx_irq_en <= w_data[CT_TX_IRQ_EN];
    end
  end

  logic tx_line, rx_in;
`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (reset)        loopback <= 1'b0;
    else if (wr_ctrl) loopback <= w_data[CT_LOOPBACK];
  end
  assign o_Tx  = tx_line | loopback;
  assign rx_in = loopback ? tx_line : i_Rx;
`else
  assign loopback = 1'b0;
  assign o_Tx     = tx_line;
  assign rx_in    = i_Rx;
`endif

  // Free-running baud counter; a CTRL write restarts it so the new divisor takes effect cleanly.
  logic [DIV_W-1:0] baud_cnt;
  logic             tick;
  assign tick = (baud_cnt == divisor);
  always_ff @(posedge clk) begin
    if (reset || wr_ctrl) baud_cnt <= '0;
    else if (tick)        baud_cnt <= '0;
    else                  baud_cnt <= baud_cnt + 1'b1;
  end

  logic [7:0] tx_head, rx_head, rx_shift;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;

  uart_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_data), .push_data(w_data[7:0]), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  tx_state_t       tx_state;
  logic [OS_W-1:0] tx_os;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;
  logic            tx_par, tx_second, tx_bit_done;

  assign tx_bit_done = tick && tx_os == OS_LAST;

  // The FIFO is popped on the same cycle the next START begins, so frames can run back to back.
  always_comb begin
    tx_pop = 1'b0;
    if (!tx_empty) begin
      if (tx_state == TX_IDLE) tx_pop = 1'b1;
      else if (tx_state == TX_STOP && tx_bit_done && (tx_second || !stop2)) tx_pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      tx_os     <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_second <= 1'b0;
      tx_line   <= 1'b1;
    end else begin
      if (tx_state != TX_IDLE && tick) tx_os <= tx_bit_done ? '0 : tx_os + 1'b1;
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          tx_state <= TX_START;
          tx_line  <= 1'b0;
          tx_shift <= tx_head;
          tx_par   <= ^tx_head ^ par_odd;
          tx_os    <= '0;
        end
        TX_START: if (tx_bit_done) begin
          tx_state <= TX_DATA;
          tx_line  <= tx_shift[0];
          tx_bit   <= '0;
        end
        TX_DATA: if (tx_bit_done) begin
          if (tx_bit == 3'd7) begin
            tx_state  <= par_en ? TX_PARITY : TX_STOP;
            tx_line   <= par_en ? tx_par : 1'b1;
            tx_second <= 1'b0;
          end else begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_line  <= tx_shift[1];
            tx_bit   <= tx_bit + 1'b1;
          end
        end
        TX_PARITY: if (tx_bit_done) begin
          tx_state  <= TX_STOP;
          tx_line   <= 1'b1;
          tx_second <= 1'b0;
        end
        TX_STOP: if (tx_bit_done) begin
          if (stop2 && !tx_second) begin
            tx_second <= 1'b1;
          end else if (tx_pop) begin
            tx_state <= TX_START;
            tx_line  <= 1'b0;
            tx_shift <= tx_head;
            tx_par   <= ^tx_head ^ par_odd;
          end else begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic [1:0]      rx_sync;
  logic            rx_s, rx_prev, rx_sample, rx_par_bad, rx_frame_bad;
  rx_state_t       rx_state;
  logic [OS_W-1:0] rx_os;
  logic [2:0]      rx_bit;

  assign rx_s         = rx_sync[1];
  assign rx_sample    = tick && rx_os == ((rx_state == RX_START) ? OS_MID : OS_LAST);
  assign rx_push      = rx_state == RX_STOP && rx_sample;
  assign rx_par_bad   = rx_state == RX_PARITY && rx_sample && (rx_s != (^rx_shift ^ par_odd));
  assign rx_frame_bad = rx_push && !rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rx_in};
      rx_prev <= rx_s;
      if (rx_state != RX_IDLE && tick) rx_os <= rx_sample ? '0 : rx_os + 1'b1;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s) begin
          rx_state <= RX_START;
          rx_os    <= '0;
        end
        RX_START: if (rx_sample) begin
          rx_state <= rx_s ? RX_IDLE : RX_DATA;
          rx_bit   <= '0;
        end
        RX_DATA: if (rx_sample) begin
          rx_shift <= {rx_s, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= par_en ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: if (rx_sample) rx_state <= RX_STOP;
        RX_STOP:   if (rx_sample) rx_state <= RX_IDLE;
        default:   rx_state <= RX_IDLE;
      endcase
    end
  end

  logic overrun, parity_err, frame_err, overrun_set;
  assign overrun_set = rx_push && rx_full && !(rx_pop && !rx_empty);

  // Setting wins over a same-cycle CLEAR so no error event is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_clear && w_data[ST_OVERRUN])    overrun    <= 1'b0;
      if (wr_clear && w_data[ST_PARITY_ERR]) parity_err <= 1'b0;
      if (wr_clear && w_data[ST_FRAME_ERR])  frame_err  <= 1'b0;
      if (overrun_set)  overrun    <= 1'b1;
      if (rx_par_bad)   parity_err <= 1'b1;
      if (rx_frame_bad) frame_err  <= 1'b1;
      irq <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty) | overrun | parity_err | frame_err;
    end
  end

  always_comb begin
    r_data = '0;
    case (reg_sel)
      REG_DATA: if (!rx_empty) r_data[7:0] = rx_head;
      REG_STATUS: begin
        r_data[ST_RX_NONEMPTY]        = ~rx_empty;
        r_data[ST_RX_FULL]            = rx_full;
        r_data[ST_TX_EMPTY]           = tx_empty;
        r_data[ST_TX_FULL]            = tx_full;
        r_data[ST_TX_BUSY]            = tx_state != TX_IDLE;
        r_data[ST_OVERRUN]            = overrun;
        r_data[ST_PARITY_ERR]         = parity_err;
        r_data[ST_FRAME_ERR]          = frame_err;
        r_data[ST_RX_COUNT_LSB +: 8]  = 8'(rx_count);
      end
      REG_CTRL: begin
        r_data[DIV_W-1:0]    = divisor;
        r_data[CT_PAR_EN]    = par_en;
        r_data[CT_PAR_ODD]   = par_odd;
        r_data[CT_STOP2]     = stop2;
        r_data[CT_RX_IRQ_EN] = rx_irq_en;
        r_data[CT_TX_IRQ_EN] = tx_irq_en;
        r_data[CT_LOOPBACK]  = loopback;
      end
      default: r_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register access, TX framing, RX with scoreboard, errors, overrun, reset.
`timescale 1ns/1ps
module tb_uart_mmio;

  localparam int RX_DEPTH   = 8;
  localparam int TX_DEPTH   = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV        = 15;
  localparam int BIT_CLKS   = (DIV + 1) * OVERSAMPLE;

  localparam logic [15:0] A_DATA   = 16'hF000;
  localparam logic [15:0] A_STATUS = 16'hF004;
  localparam logic [15:0] A_CTRL   = 16'hF008;
  localparam logic [15:0] A_CLEAR  = 16'hF00C;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [31:0] w_data;
  logic        we, re;
  logic [31:0] r_data;
  logic        i_Rx;
  logic        o_Tx;
  logic        irq;

  uart_mmio #(
    .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .OVERSAMPLE(OVERSAMPLE), .DIV_W(16), .DIV_RESET(325)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .w_data(w_data), .we(we), .re(re),
    .r_data(r_data), .i_Rx(i_Rx), .o_Tx(o_Tx), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // driver tasks
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; w_data = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a; re = 1'b1;
    #1 d = r_data;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic rx_read_check(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    e = 8'h00;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    bus_read(A_DATA, d);
    check(tag, d, {24'b0, e});
  endtask

  task automatic drive_bit(input logic b);
    i_Rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic uart_send(input logic [7:0] d, input bit with_par, input logic par_bit,
                           input logic stop_bit, input bit expect_store);
    if (expect_store) exp_q.push_back(d);
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (with_par) drive_bit(par_bit);
    drive_bit(stop_bit);
    i_Rx = 1'b1;
    repeat (32) @(posedge clk);
  endtask

  task automatic wait_tx_low(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_Tx == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  frame;
    logic [7:0]  rnd;
    bit          busy_gone, low_seen;

    address = '0; w_data = '0; we = 1'b0; re = 1'b0; i_Rx = 1'b1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check("reset_tx", 32'(o_Tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    check_reg("reset_status", A_STATUS, 32'h0000_0004);
    check_reg("reset_ctrl", A_CTRL, 32'h0000_0145);
    check_reg("empty_data_read", A_DATA, 32'h0);

    // TX framing of 0xA5
    bus_write(A_CTRL, DIV);
    check_reg("ctrl_div", A_CTRL, 32'h0000_000F);
    bus_write(A_DATA, 32'hA5);
    wait_tx_low("tx_start_seen", 200);
    frame = {1'b1, 8'hA5, 1'b0};
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("tx_bit0", 32'(o_Tx), 32'(frame[0]));
    for (int k = 1; k < 10; k++) begin
      repeat (BIT_CLKS) @(negedge clk);
      check($sformatf("tx_bit%0d", k), 32'(o_Tx), 32'(frame[k]));
    end
    check_reg("tx_busy_in_stop", A_STATUS, 32'h0000_0014);
    busy_gone = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus_read(A_STATUS, d);
      if (d[4] == 1'b0) begin
        busy_gone = 1'b1;
        break;
      end
    end
    check("tx_busy_fall", 32'(busy_gone), 32'd1);
    check_reg("tx_done_status", A_STATUS, 32'h0000_0004);

    // RX one byte
    uart_send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    check_reg("rx_status", A_STATUS, 32'h0000_0105);
    rx_read_check("rx_data_3c");
    check_reg("rx_drained", A_STATUS, 32'h0000_0004);

    // parity error, even parity
    bus_write(A_CTRL, DIV | (1 << 16));
    uart_send(8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
    check_reg("par_status", A_STATUS, 32'h0000_0145);
    @(negedge clk);
    check("par_irq", 32'(irq), 32'd1);
    bus_write(A_CLEAR, 32'h40);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("par_irq_cleared", 32'(irq), 32'd0);
    check_reg("par_cleared", A_STATUS, 32'h0000_0105);
    rx_read_check("par_data_01");
    uart_send(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
    check_reg("par_ok_status", A_STATUS, 32'h0000_0105);
    rx_read_check("par_data_03");

    // frame error: stop bit low, byte still stored
    bus_write(A_CTRL, DIV);
    uart_send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    check_reg("frame_status", A_STATUS, 32'h0000_0185);
    @(negedge clk);
    check("frame_irq", 32'(irq), 32'd1);
    bus_write(A_CLEAR, 32'h80);
    rx_read_check("frame_data_81");
    check_reg("frame_cleared", A_STATUS, 32'h0000_0004);

    // overrun: RX_DEPTH+1 bytes, the last one is dropped
    for (int k = 0; k < RX_DEPTH + 1; k++) begin
      rnd = 8'($urandom_range(0, 255));
      uart_send(rnd, 1'b0, 1'b0, 1'b1, k < RX_DEPTH);
    end
    check_reg("ovr_status", A_STATUS, 32'h0000_0827);
    for (int k = 0; k < RX_DEPTH; k++) rx_read_check($sformatf("ovr_data%0d", k));
    rx_read_check("ovr_empty_read");
    check_reg("ovr_sticky", A_STATUS, 32'h0000_0024);
    bus_write(A_CLEAR, 32'h20);
    check_reg("ovr_cleared", A_STATUS, 32'h0000_0004);

`ifdef UART_LOOPBACK_EN
    // loopback: line stays high, byte returns through RX
    bus_write(A_CTRL, DIV | (1 << 21));
    check_reg("lb_ctrl", A_CTRL, 32'h0020_000F);
    exp_q.push_back(8'h5A);
    bus_write(A_DATA, 32'h5A);
    low_seen = 1'b0;
    for (int i = 0; i < 2 * 10 * BIT_CLKS / 2 + 400; i++) begin
      @(negedge clk);
      if (o_Tx == 1'b0) low_seen = 1'b1;
    end
    check("lb_tx_high", 32'(low_seen), 32'd0);
    check_reg("lb_status", A_STATUS, 32'h0000_0105);
    rx_read_check("lb_data_5a");
`else
    low_seen = 1'b0;
`endif

    // fill TX, then reset mid-frame
    bus_write(A_CTRL, DIV);
    for (int k = 0; k < TX_DEPTH + 2; k++) bus_write(A_DATA, 32'(8'h11 * (k + 1)));
    check_reg("tx_full_status", A_STATUS, 32'h0000_0018);
    wait_tx_low("midframe_start", 400);
    repeat (2 * BIT_CLKS + BIT_CLKS / 4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midreset_tx", 32'(o_Tx), 32'd1);
    check_reg("midreset_status", A_STATUS, 32'h0000_0004);
    check_reg("midreset_ctrl", A_CTRL, 32'h0000_0145);
    repeat (50) @(negedge clk);
    check("midreset_idle", 32'(o_Tx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
